params_mem_banked: RTL and testbench



---
 rtl/params_mem_banked_pkg.sv | 66 ++++++
 rtl/params_bank.sv | 59 +++++
 rtl/params_mem_banked.sv | 202 ++++++++++++++++++++
 tb/tb_params_mem_banked.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_mem_banked_pkg.sv
// Shared types, constants and fixed-point cast helpers for the banked parameter memory.
// Cast functions take the word widths as arguments so every instance can share them.
package params_mem_banked_pkg;

  localparam int CIM_PARAMS_NUM_BANKS          = 2;
  localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 15872;

  // Encoding value equals the number of integer bits (sign included) in the stored word.
  typedef enum logic [2:0] {
    PARAMS_FX_2_X = 3'd2,
    PARAMS_FX_3_X = 3'd3,
    PARAMS_FX_4_X = 3'd4,
    PARAMS_FX_5_X = 3'd5
  } FxFormatParams_t;

  function automatic int fx_int_bits(input FxFormatParams_t fmt);
    case (fmt)
      PARAMS_FX_2_X: return 2;
      PARAMS_FX_3_X: return 3;
      PARAMS_FX_5_X: return 5;
      default:       return 4;
    endcase
  endfunction

  // Stored word -> compute word: sign-extend, then move the binary point up to comp_frac.
  function automatic logic [63:0] fx_sto_to_comp(
    input logic [63:0]     sto,
    input int              sto_w,
    input int              comp_frac,
    input FxFormatParams_t fmt
  );
    logic signed [63:0] v;
    int                 sh;
    sh = comp_frac - (sto_w - fx_int_bits(fmt));
    v  = $signed(sto << (64 - sto_w)) >>> (64 - sto_w);
    return v <<< sh;
  endfunction

  // Compute word -> stored word: arithmetic shift floors toward -inf; the caller keeps the
  // low sto_w bits, so without saturation an overflow simply wraps.
  function automatic logic [63:0] fx_comp_to_sto(
    input logic [63:0]     comp,
    input int              comp_w,
    input int              sto_w,
    input int              comp_frac,
    input FxFormatParams_t fmt,
    input bit              sat_en
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    int                 sh;
    sh = comp_frac - (sto_w - fx_int_bits(fmt));
    v  = $signed(comp << (64 - comp_w)) >>> (64 - comp_w);
    v  = v >>> sh;
    hi = (64'sd1 <<< (sto_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (sto_w - 1));
    if (sat_en && (v > hi)) begin
      v = hi;
    end else if (sat_en && (v < lo)) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/params_bank.sv
// One single-ported parameter bank; write wins the shared macro address port.
// USE_MEM_MODEL selects the behavioural mem_model, otherwise a RAM is inferred.
module params_bank #(
  parameter int BANK_DEPTH = 15872,
  parameter int STO_WIDTH  = 15,
  parameter int ADDR_W     = 14
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [STO_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [STO_WIDTH-1:0] rd_data
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;

  assign mem_addr = wr_en ? wr_addr : rd_addr;
  assign mem_en   = wr_en | rd_en;
  assign mem_we   = wr_en;

`ifdef USE_MEM_MODEL
  mem_model #(
    .DEPTH (BANK_DEPTH),
    .WIDTH (STO_WIDTH)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (wr_data),
    .dout (rd_data)
  );
`else
  logic [STO_WIDTH-1:0] mem [BANK_DEPTH];
  logic [STO_WIDTH-1:0] rd_data_reg;

  // Read register only loads on a read, so the last read word is held between reads.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= wr_data;
      end else begin
        rd_data_reg <= mem[mem_addr];
      end
    end
  end

  assign rd_data = rd_data_reg;
`endif

`ifdef ENABLE_ASSERTIONS
  a_one_access: assert property (@(posedge clk) !(wr_en && rd_en));
`endif

endmodule

// File: rtl/params_mem_banked.sv
// Banked parameter memory: global address split over NUM_BANKS banks, format casts on access,
// conflict stalls, 1/2-cycle read pipeline. Define PARAMS_MEM_SAT_EN for saturating writes.
module params_mem_banked
  import params_mem_banked_pkg::*;
#(
  parameter int  NUM_BANKS  = CIM_PARAMS_NUM_BANKS,
  parameter int  BANK_DEPTH = CIM_PARAMS_BANK_SIZE_NUM_WORD,
  parameter int  STO_WIDTH  = 15,
  parameter int  COMP_WIDTH = 22,
  parameter int  COMP_FRAC  = 16,
  parameter int  OUT_REG    = 0,
  localparam int ADDR_W     = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [COMP_WIDTH-1:0] wr_data,
  input  FxFormatParams_t       wr_format,
  output logic                  wr_err,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  FxFormatParams_t       rd_format,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [COMP_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  output logic [15:0]           rd_stall_cnt
);

  localparam int TOTAL_WORDS = NUM_BANKS * BANK_DEPTH;
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LOCAL_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
`ifdef PARAMS_MEM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [BANK_W-1:0]  wr_bank;
  logic [BANK_W-1:0]  rd_bank;
  logic [LOCAL_W-1:0] wr_local;
  logic [LOCAL_W-1:0] rd_local;
  logic               wr_oor;
  logic               rd_oor;

  // Comparator chain against bank base addresses; avoids a divider for odd BANK_DEPTH.
  always_comb begin : addr_decode
    logic [31:0] wa;
    logic [31:0] ra;
    wa       = 32'(wr_addr);
    ra       = 32'(rd_addr);
    wr_bank  = '0;
    rd_bank  = '0;
    wr_local = LOCAL_W'(wa);
    rd_local = LOCAL_W'(ra);
    for (int b = 1; b < NUM_BANKS; b++) begin
      if (wa >= 32'(b * BANK_DEPTH)) begin
        wr_bank  = BANK_W'(b);
        wr_local = LOCAL_W'(wa - 32'(b * BANK_DEPTH));
      end
      if (ra >= 32'(b * BANK_DEPTH)) begin
        rd_bank  = BANK_W'(b);
        rd_local = LOCAL_W'(ra - 32'(b * BANK_DEPTH));
      end
    end
    wr_oor = (wa >= 32'(TOTAL_WORDS));
    rd_oor = (ra >= 32'(TOTAL_WORDS));
  end

  logic                 wr_hit;
  logic                 rd_acc;
  logic                 rd_hit;
  logic [STO_WIDTH-1:0] wr_sto;

  assign wr_hit   = wr_en & ~rst & ~wr_oor;
  assign rd_ready = ~rst & ~(wr_en & ~wr_oor & (wr_bank == rd_bank));
  assign rd_acc   = rd_en & rd_ready;
  assign rd_hit   = rd_acc & ~rd_oor;
  assign wr_sto   = STO_WIDTH'(fx_comp_to_sto(64'(wr_data), COMP_WIDTH, STO_WIDTH, COMP_FRAC,
                                              wr_format, SAT_EN));

  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  logic [STO_WIDTH-1:0] bank_rdata [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_we[gi] = wr_hit & (wr_bank == BANK_W'(gi));
    assign bank_re[gi] = rd_hit & (rd_bank == BANK_W'(gi));

    params_bank #(
      .BANK_DEPTH (BANK_DEPTH),
      .STO_WIDTH  (STO_WIDTH),
      .ADDR_W     (LOCAL_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[gi]),
      .wr_addr (wr_local),
      .wr_data (wr_sto),
      .rd_en   (bank_re[gi]),
      .rd_addr (rd_local),
      .rd_data (bank_rdata[gi])
    );
  end

  // Latched copy of the accepted read; the output mux and cast never look at live inputs.
  logic              s1_valid_reg;
  logic              s1_live_reg;
  logic              s1_err_reg;
  logic [BANK_W-1:0] s1_bank_reg;
  FxFormatParams_t   s1_fmt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_live_reg  <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_bank_reg  <= '0;
      s1_fmt_reg   <= PARAMS_FX_4_X;
    end else begin
      s1_valid_reg <= rd_acc;
      if (rd_acc) begin
        s1_live_reg <= 1'b1;
        s1_err_reg  <= rd_oor;
        s1_bank_reg <= rd_bank;
        s1_fmt_reg  <= rd_format;
      end
    end
  end

  // Bank read registers and s1 copies only change on an accept, so this holds between reads.
  logic [COMP_WIDTH-1:0] s1_data;

  always_comb begin
    s1_data = '0;
    if (s1_live_reg && !s1_err_reg) begin
      s1_data = COMP_WIDTH'(fx_sto_to_comp(64'(bank_rdata[s1_bank_reg]), STO_WIDTH, COMP_FRAC,
                                           s1_fmt_reg));
    end
  end

  logic                  out_valid;
  logic                  out_err;
  logic [COMP_WIDTH-1:0] out_data;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid_reg;
    logic                  out_err_reg;
    logic [COMP_WIDTH-1:0] out_data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_reg <= 1'b0;
        out_err_reg   <= 1'b0;
        out_data_reg  <= '0;
      end else begin
        out_valid_reg <= s1_valid_reg;
        out_err_reg   <= s1_valid_reg & s1_err_reg;
        if (s1_valid_reg) begin
          out_data_reg <= s1_data;
        end
      end
    end

    assign out_valid = out_valid_reg;
    assign out_err   = out_err_reg;
    assign out_data  = out_data_reg;
  end else begin : g_no_out_reg
    assign out_valid = s1_valid_reg;
    assign out_err   = s1_valid_reg & s1_err_reg;
    assign out_data  = s1_data;
  end

  // Masking with rst drops a read that is already in flight when reset arrives.
  assign rd_valid = out_valid & ~rst;
  assign rd_err   = out_err & ~rst;
  assign rd_data  = rst ? '0 : out_data;

  logic        wr_err_reg;
  logic [15:0] rd_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_reg       <= 1'b0;
      rd_stall_cnt_reg <= '0;
    end else begin
      wr_err_reg <= wr_en & wr_oor;
      if (rd_en && !rd_ready && (rd_stall_cnt_reg != 16'hFFFF)) begin
        rd_stall_cnt_reg <= rd_stall_cnt_reg + 16'd1;
      end
    end
  end

  assign wr_err       = wr_err_reg & ~rst;
  assign rd_stall_cnt = rd_stall_cnt_reg;

`ifdef ENABLE_ASSERTIONS
  a_rd_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (rd_en && !rd_ready) |=> $stable(rd_addr));
`endif

endmodule

// File: tb/tb_params_mem_banked.sv
// Randomised scoreboard bench for params_mem_banked: stimulus pushes expected reads into a
// queue from an address/value model; a negedge monitor pops and compares on rd_valid.
module tb_params_mem_banked;
  import params_mem_banked_pkg::*;

  localparam int NB      = 2;
  localparam int BD      = 15872;
  localparam int TOTAL   = NB * BD;
  localparam int OUT_REG = 0;
  localparam int LAT     = 1 + OUT_REG;
`ifdef PARAMS_MEM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [14:0]     wr_addr;
  logic [21:0]     wr_data;
  FxFormatParams_t wr_format;
  logic            wr_err;
  logic            rd_en;
  logic [14:0]     rd_addr;
  FxFormatParams_t rd_format;
  logic            rd_ready;
  logic            rd_valid;
  logic [21:0]     rd_data;
  logic            rd_err;
  logic [15:0]     rd_stall_cnt;

  params_mem_banked #(
    .NUM_BANKS  (NB),
    .BANK_DEPTH (BD),
    .STO_WIDTH  (15),
    .COMP_WIDTH (22),
    .COMP_FRAC  (16),
    .OUT_REG    (OUT_REG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_format    (wr_format),
    .wr_err       (wr_err),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_format    (rd_format),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .rd_stall_cnt (rd_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    logic        err;
    logic [21:0] data;
  } exp_t;

  int   checks;
  int   failures;
  int   cyc;
  int   exp_stall;
  int   mem_m [int];
  int   written_q [$];
  exp_t exp_q [$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the stored word is the value scaled by 2^frac, floored, then wrapped
  // modulo 2^15 or clamped to the signed 15-bit range.
  function automatic int k_of(input int f);
    return (f >= 2 && f <= 5) ? f : 4;
  endfunction

  function automatic int model_store(input int v, input int f);
    int d;
    int q;
    d = 1 << (16 - (15 - k_of(f)));
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (SAT && q > 16383)  q = 16383;
    if (SAT && q < -16384) q = -16384;
    return ((q % 32768) + 32768) % 32768;
  endfunction

  function automatic int model_load(input int sto, input int f);
    int s;
    s = (sto >= 16384) ? sto - 32768 : sto;
    return s * (1 << (16 - (15 - k_of(f))));
  endfunction

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic step(input logic we, input int wa, input int wd, input int wf,
                      input logic re, input int ra, input int rf, input bit drop,
                      output logic acc);
    logic exp_rdy;
    logic exp_werr;
    exp_t e;
    int   v;
    wr_en     = we;
    wr_addr   = wa[14:0];
    wr_data   = wd[21:0];
    wr_format = FxFormatParams_t'(wf[2:0]);
    rd_en     = re;
    rd_addr   = ra[14:0];
    rd_format = FxFormatParams_t'(rf[2:0]);
    #1;
    exp_rdy = !(we && wa < TOTAL && (wa / BD) == (ra / BD));
    check("rd_ready", rd_ready, exp_rdy);
    acc = re && exp_rdy;
    if (acc && !drop) begin
      e.cyc  = cyc + LAT;
      e.addr = ra;
      e.err  = (ra >= TOTAL);
      v      = (ra >= TOTAL) ? 0 : model_load(mem_m[ra], rf);
      e.data = v[21:0];
      exp_q.push_back(e);
    end
    if (re && !exp_rdy && exp_stall < 65535) exp_stall++;
    if (we && wa < TOTAL) begin
      mem_m[wa] = model_store(wd, wf);
      written_q.push_back(wa);
      $display("wr addr=%0d data=%0d fmt=%0d", wa, wd, wf);
    end
    exp_werr = we && (wa >= TOTAL);
    @(posedge clk);
    #1;
    check("wr_err", wr_err, exp_werr);
    check("rd_stall_cnt", rd_stall_cnt, exp_stall);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 4, 0, 0, 4, 0, a);
  endtask

  // Monitor: pops one expectation per rd_valid and flags reads that never show up.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=valid data=%0d required=no_valid", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_cycle", cyc, mon_e.cyc);
          check("rd_err", rd_err, mon_e.err);
          check("rd_data", rd_data, mon_e.data);
          $display("rd addr=%0d data=%0d err=%0b cyc=%0d", mon_e.addr, rd_data, rd_err, cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL rd_missing actual=no_valid required=valid_at_cyc_%0d addr=%0d",
                 exp_q[0].cyc, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    logic we;
    logic re;
    int   wa;
    int   wd;
    int   wf;
    int   ra;
    int   rf;
    int   pend_addr;
    int   pend_fmt;

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    exp_stall = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_format = PARAMS_FX_4_X;
    rd_en     = 1'b0;
    rd_addr   = '0;
    rd_format = PARAMS_FX_4_X;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_ready", rd_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_stall_cnt", rd_stall_cnt, 0);
    rst = 1'b0;

    // 1.5 in 4_X, read back the very next cycle; encoding 7 behaves as 4_X
    step(1, 5, 98304, 4, 0, 0, 4, 0, acc);
    step(0, 0, 0, 4, 1, 5, 4, 0, acc);
    step(0, 0, 0, 4, 1, 5, 7, 0, acc);
    // bank boundary, back-to-back reads
    step(1, 15871, -12345, 3, 0, 0, 4, 0, acc);
    step(1, 15872, 54321, 5, 0, 0, 4, 0, acc);
    step(0, 0, 0, 4, 1, 15871, 3, 0, acc);
    step(0, 0, 0, 4, 1, 15872, 5, 0, acc);
    // parallel bank access, then a same-bank conflict
    step(1, 100, -777, 2, 0, 0, 4, 0, acc);
    step(1, 20001, 4242, 4, 0, 0, 4, 0, acc);
    step(1, 20000, 999, 4, 1, 100, 2, 0, acc);
    step(1, 20000, 1000, 4, 1, 20001, 4, 0, acc);
    step(0, 0, 0, 4, 1, 20001, 4, 0, acc);
    // overflowing writes
    step(1, 300, 1310720, 4, 0, 0, 4, 0, acc);
    step(1, 301, -1310720, 4, 1, 300, 4, 0, acc);
    step(0, 0, 0, 4, 1, 301, 4, 0, acc);
    // out-of-range read and write
    step(0, 0, 0, 4, 1, 31744, 4, 0, acc);
    step(1, 32000, 5, 4, 0, 0, 4, 0, acc);
    idle(3);

    // accept a read, then reset the next cycle: it must never appear
    step(0, 0, 0, 4, 1, 15872, 5, 1, acc);
    rst     = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 15'd5;
    wr_data = 22'd123;
    #1;
    check("rstmid_rd_valid", rd_valid, 0);
    check("rstmid_rd_err", rd_err, 0);
    check("rstmid_rd_data", rd_data, 0);
    check("rstmid_rd_ready", rd_ready, 0);
    @(posedge clk);
    #1;
    check("rstmid_stall_cnt", rd_stall_cnt, 0);
    check("rstmid_wr_err", wr_err, 0);
    wr_en     = 1'b0;
    rst       = 1'b0;
    exp_stall = 0;
    #1;
    check("rstpost_rd_data", rd_data, 0);
    check("rstpost_rd_valid", rd_valid, 0);
    step(0, 0, 0, 4, 1, 5, 4, 0, acc);
    idle(2);

    // randomised traffic; a stalled read is held until accepted
    pend_addr = -1;
    pend_fmt  = 4;
    for (int i = 0; i < 500; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) wa = TOTAL + int'($urandom_range(0, 1023));
      else wa = int'($urandom_range(0, 1)) * BD + int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) wd = int'($urandom_range(0, 4194303)) - 2097152;
      else wd = int'($urandom_range(0, 131071)) - 65536;
      wf = int'($urandom_range(0, 7));
      re = 1'b0;
      ra = 0;
      rf = 4;
      if (pend_addr >= 0) begin
        re = 1'b1;
        ra = pend_addr;
        rf = pend_fmt;
      end else if (written_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        re = 1'b1;
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        rf = int'($urandom_range(0, 7));
      end
      step(we, wa, wd, wf, re, ra, rf, 0, acc);
      if (re && !acc) begin
        pend_addr = ra;
        pend_fmt  = rf;
      end else begin
        pend_addr = -1;
      end
    end
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
